// File: rtl/dfp_burst_responder_pkg.sv
// Shared types and default geometry for the DFP burst responder and the caches
// that connect to it.
//
// Contents:
//   ADDR_BITS_DEF / LINE_BITS_DEF / BEAT_BITS_DEF / TIMEOUT_DEF - default geometry
//   responder_state_t - responder FSM state encoding
package dfp_burst_responder_pkg;

  localparam int unsigned ADDR_BITS_DEF = 32;
  localparam int unsigned LINE_BITS_DEF = 256;
  localparam int unsigned BEAT_BITS_DEF = 64;
  localparam int unsigned TIMEOUT_DEF   = 1023;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_DATA = 3'd4,
    RESP    = 3'd5
  } responder_state_t;

endpackage

// File: rtl/dfp_burst_responder_line_beat_buffer.sv
// Cacheline register viewed as BURST_LEN beats. Beat 0 is line bits [BEAT_BITS-1:0].
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (buffer clears to 0)
//   clear      - zero the whole line (highest priority)
//   load       - load the full line from load_line
//   load_line  - full-line load data
//   wr_en      - write wr_beat into beat slot wr_idx
//   wr_idx     - beat slot for the write port
//   wr_beat    - beat write data
//   rd_idx     - beat slot for the read mux
//   rd_beat    - registered beat at rd_idx
//   line_next  - line value the register takes at the next edge
module dfp_burst_responder_line_beat_buffer #(
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned BEAT_BITS = 64,
  localparam int unsigned BURST_LEN = LINE_BITS / BEAT_BITS,
  localparam int unsigned IDX_W     = $clog2(BURST_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic [LINE_BITS-1:0] load_line,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [BEAT_BITS-1:0] wr_beat,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [BEAT_BITS-1:0] rd_beat,
  output logic [LINE_BITS-1:0] line_next
);

  logic [BURST_LEN-1:0][BEAT_BITS-1:0] beats_q;
  logic [BURST_LEN-1:0][BEAT_BITS-1:0] beats_d;

  // Next-line selection: clear beats load beats single-beat write.
  always_comb begin
    beats_d = beats_q;
    if (clear) begin
      beats_d = '0;
    end else if (load) begin
      beats_d = load_line;
    end else if (wr_en) begin
      beats_d[wr_idx] = wr_beat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_q <= '0;
    end else begin
      beats_q <= beats_d;
    end
  end

  assign rd_beat   = beats_q[rd_idx];
  // Lets the last read beat land in dfp_rdata on the same edge it is captured.
  assign line_next = beats_d;

endmodule

// File: rtl/dfp_burst_responder.sv
// Memory-side responder for the cache DFP interface. Each whole-line
// dfp_read/dfp_write becomes a fixed BURST_LEN-beat burst on the narrower
// bmem bus and is answered with a one-cycle dfp_resp pulse.
//
// Optional feature: define DFP_BURST_RESPONDER_TIMEOUT_EN to add a no-progress
// timeout (TIMEOUT cycles) that sets sticky bmem_err, zeroes the line buffer and
// completes the request anyway. Without it bmem_err is tied 0 and stalls wait.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   dfp_addr     - line address (offset bits ignored)
//   dfp_read     - read request, held until dfp_resp
//   dfp_write    - write request, held until dfp_resp
//   dfp_wdata    - write line
//   dfp_rdata    - read line, updated when a read completes
//   dfp_resp     - one-cycle completion pulse
//   bmem_addr    - line-aligned burst address
//   bmem_read    - read burst command, held until bmem_ready
//   bmem_write   - write beat strobe, BURST_LEN consecutive cycles
//   bmem_wdata   - write beat data
//   bmem_ready   - memory accepts a burst command
//   bmem_rdata   - read beat data
//   bmem_rvalid  - read beat valid
//   bmem_err     - sticky timeout flag
module dfp_burst_responder
  import dfp_burst_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
  parameter int unsigned LINE_BITS = LINE_BITS_DEF,
  parameter int unsigned BEAT_BITS = BEAT_BITS_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] dfp_addr,
  input  logic                 dfp_read,
  input  logic                 dfp_write,
  input  logic [LINE_BITS-1:0] dfp_wdata,
  output logic [LINE_BITS-1:0] dfp_rdata,
  output logic                 dfp_resp,
  output logic [ADDR_BITS-1:0] bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid,
  output logic                 bmem_err
);

  localparam int unsigned BURST_LEN  = LINE_BITS / BEAT_BITS;
  localparam int unsigned CNT_W      = $clog2(BURST_LEN);
  localparam int unsigned LINE_BYTES = LINE_BITS / 8;
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~ADDR_BITS'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0]     LAST_BEAT  = CNT_W'(BURST_LEN - 1);

  responder_state_t     state_q;
  responder_state_t     state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 buf_clear;
  logic                 buf_load;
  logic                 buf_wr;
  logic [BEAT_BITS-1:0] rd_beat;
  logic [LINE_BITS-1:0] buf_next;
  logic                 rd_done;
  logic                 wr_active_d;
  logic                 tmo;

  dfp_burst_responder_line_beat_buffer #(
    .LINE_BITS (LINE_BITS),
    .BEAT_BITS (BEAT_BITS)
  ) u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (buf_clear),
    .load      (buf_load),
    .load_line (dfp_wdata),
    .wr_en     (buf_wr),
    .wr_idx    (cnt_q),
    .wr_beat   (bmem_rdata),
    .rd_idx    (cnt_d),
    .rd_beat   (rd_beat),
    .line_next (buf_next)
  );

  // Next state, beat counter and line-buffer controls.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_clear = 1'b0;
    buf_load  = 1'b0;
    buf_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        // Read wins if both are (illegally) high.
        if (dfp_read) begin
          state_d = RD_REQ;
        end else if (dfp_write) begin
          state_d  = WR_REQ;
          buf_load = 1'b1;
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          state_d = RD_DATA;
          cnt_d   = '0;
        end
      end
      RD_DATA: begin
        if (bmem_rvalid) begin
          buf_wr = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WR_REQ: begin
        // Beat 0 is already on the bus; acceptance consumes it.
        if (bmem_ready) begin
          state_d = WR_DATA;
          cnt_d   = CNT_W'(1);
        end
      end
      WR_DATA: begin
        if (cnt_q == LAST_BEAT) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Timeout completes the request with an all-zero line.
    if (tmo) begin
      state_d   = RESP;
      cnt_d     = '0;
      buf_clear = 1'b1;
      buf_wr    = 1'b0;
    end
  end

  assign rd_done     = (state_q == RD_REQ || state_q == RD_DATA) && (state_d == RESP);
  assign wr_active_d = (state_d == WR_REQ) || (state_d == WR_DATA);

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dfp_resp   <= 1'b0;
      dfp_rdata  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_addr  <= '0;
      bmem_wdata <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dfp_resp   <= (state_d == RESP);
      bmem_read  <= (state_d == RD_REQ);
      bmem_write <= wr_active_d;
      if (state_q == IDLE && state_d != IDLE) begin
        bmem_addr <= dfp_addr & ALIGN_MASK;
      end
      // Beat 0 comes straight from dfp_wdata while the buffer is loading.
      if (state_q == IDLE && state_d == WR_REQ) begin
        bmem_wdata <= dfp_wdata[BEAT_BITS-1:0];
      end else if (wr_active_d) begin
        bmem_wdata <= rd_beat;
      end else begin
        bmem_wdata <= '0;
      end
      if (rd_done) begin
        dfp_rdata <= buf_next;
      end
    end
  end

`ifdef DFP_BURST_RESPONDER_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_FIRE = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

  logic [TMR_W-1:0] tmr_q;
  logic             stall_state;
  logic             progress;
  logic             err_q;

  assign stall_state = (state_q == RD_REQ) || (state_q == RD_DATA) || (state_q == WR_REQ);
  assign progress    = ((state_q == RD_REQ)  && bmem_ready) ||
                       ((state_q == RD_DATA) && bmem_rvalid) ||
                       ((state_q == WR_REQ)  && bmem_ready);
  // Fires on the TIMEOUT-th consecutive cycle without progress.
  assign tmo = stall_state && !progress && (tmr_q == TMR_FIRE);

  // No-progress cycle counter; saturates so long idle periods cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_d != state_q || progress) begin
        tmr_q <= '0;
      end else if (tmr_q != TMR_MAX) begin
        tmr_q <= tmr_q + TMR_W'(1);
      end
      if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bmem_err = err_q;
`else
  assign tmo      = 1'b0;
  assign bmem_err = 1'b0;

  // TIMEOUT only matters when the timeout logic is compiled in.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

endmodule

// File: tb/tb_dfp_burst_responder.sv
// Randomized self-checking bench for dfp_burst_responder. A transaction-level
// model supplies bmem beats, predicts the returned line, the write beat order,
// latencies and the held dfp_rdata value.
module tb_dfp_burst_responder;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;
  localparam int unsigned BW = 64;
  localparam int unsigned BL = LW / BW;
  localparam logic [AW-1:0] AMASK = 32'hFFFF_FFE0;

  logic          clk;
  logic          rst;
  logic [AW-1:0] dfp_addr;
  logic          dfp_read;
  logic          dfp_write;
  logic [LW-1:0] dfp_wdata;
  logic [LW-1:0] dfp_rdata;
  logic          dfp_resp;
  logic [AW-1:0] bmem_addr;
  logic          bmem_read;
  logic          bmem_write;
  logic [BW-1:0] bmem_wdata;
  logic          bmem_ready;
  logic [BW-1:0] bmem_rdata;
  logic          bmem_rvalid;
  logic          bmem_err;

  dfp_burst_responder #(
    .ADDR_BITS (AW),
    .LINE_BITS (LW),
    .BEAT_BITS (BW),
    .TIMEOUT   (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid),
    .bmem_err    (bmem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            total;
  int            bad;
  int            cyc;
  logic [LW-1:0] last_rdata;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < int'(LW / 32); i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rdata"}, dfp_rdata, '0);
    check({tag, "_resp"}, LW'(dfp_resp), '0);
    check({tag, "_bread"}, LW'(bmem_read), '0);
    check({tag, "_bwrite"}, LW'(bmem_write), '0);
    check({tag, "_baddr"}, LW'(bmem_addr), '0);
    check({tag, "_bwdata"}, LW'(bmem_wdata), '0);
    check({tag, "_err"}, LW'(bmem_err), '0);
  endtask

  // Called at a negedge; returns at the negedge after the resp cycle.
  task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                         input int rdy_delay, input int gap);
    bit seen;
    cyc = 0;
    dfp_addr = addr;
    dfp_read = 1'b1;
    bmem_ready = (rdy_delay == 0);
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      step();
      seen = bmem_read;
    end
    check("rd_req_seen", LW'(seen), LW'(1));
    check("rd_addr", LW'(bmem_addr), LW'(addr & AMASK));
    for (int i = 0; i < rdy_delay; i++) begin
      check("rd_req_held", LW'(bmem_read), LW'(1));
      step();
    end
    bmem_ready = 1'b1;
    step();
    bmem_ready = 1'b0;
    check("rd_req_drop", LW'(bmem_read), '0);
    for (int b = 0; b < int'(BL); b++) begin
      for (int g = 0; g < ((b == 0) ? 0 : gap); g++) begin
        bmem_rvalid = 1'b0;
        bmem_rdata = {$urandom, $urandom};
        step();
        check("rd_no_early_resp", LW'(dfp_resp), '0);
      end
      bmem_rvalid = 1'b1;
      bmem_rdata = line[b*BW +: BW];
      step();
      if (b < int'(BL) - 1) check("rd_no_early_resp", LW'(dfp_resp), '0);
    end
    bmem_rvalid = 1'b0;
    check("rd_resp", LW'(dfp_resp), LW'(1));
    check("rd_data", dfp_rdata, line);
    if (rdy_delay == 0 && gap == 0) check("rd_latency", LW'(cyc), LW'(BL + 2));
    last_rdata = line;
    dfp_read = 1'b0;
    step();
    check("rd_resp_pulse", LW'(dfp_resp), '0);
    check("rd_data_hold", dfp_rdata, last_rdata);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                          input int rdy_delay);
    bit seen;
    cyc = 0;
    dfp_addr = addr;
    dfp_wdata = line;
    dfp_write = 1'b1;
    bmem_ready = (rdy_delay == 0);
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      step();
      seen = bmem_write;
    end
    check("wr_req_seen", LW'(seen), LW'(1));
    check("wr_addr", LW'(bmem_addr), LW'(addr & AMASK));
    for (int i = 0; i < rdy_delay; i++) begin
      check("wr_beat0_hold", LW'(bmem_wdata), LW'(line[BW-1:0]));
      step();
    end
    bmem_ready = 1'b1;
    for (int b = 0; b < int'(BL); b++) begin
      check("wr_strobe", LW'(bmem_write), LW'(1));
      check("wr_beat", LW'(bmem_wdata), LW'(line[b*BW +: BW]));
      check("wr_no_early_resp", LW'(dfp_resp), '0);
      step();
      bmem_ready = 1'b0;
    end
    check("wr_strobe_drop", LW'(bmem_write), '0);
    check("wr_resp", LW'(dfp_resp), LW'(1));
    check("wr_rdata_kept", dfp_rdata, last_rdata);
    if (rdy_delay == 0) check("wr_latency", LW'(cyc), LW'(BL + 1));
    dfp_write = 1'b0;
    step();
    check("wr_resp_pulse", LW'(dfp_resp), '0);
  endtask

  // Read and write must never be requested together.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(dfp_read && dfp_write))
        else $error("FAIL both_requests: read=%0b write=%0b", dfp_read, dfp_write);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] line;
    logic [AW-1:0] addr;
    int            resp_seen;
    total = 0;
    bad = 0;
    cyc = 0;
    last_rdata = '0;
    rst = 1'b1;
    dfp_addr = '0;
    dfp_read = 1'b0;
    dfp_write = 1'b0;
    dfp_wdata = '0;
    bmem_ready = 1'b0;
    bmem_rdata = 64'hDEAD_BEEF_0000_0001;
    bmem_rvalid = 1'b1;  // stale beats during reset must be ignored
    step();
    step();
    check_zero_outputs("reset");
    rst = 1'b0;
    step();
    bmem_rvalid = 1'b0;
    step();
    check("idle_no_resp", LW'(dfp_resp), '0);
    check("idle_rdata", dfp_rdata, '0);

    // Directed read, back-to-back beats.
    line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h0000_1040, line, 0, 0);

    // Directed write.
    do_write(32'h0000_2000, rand_line(), 0);

    // Command stall plus gapped beats.
    do_read(32'h0000_3018, rand_line(), 3, 2);

    // Read, write, read with one idle cycle between requests.
    do_read(32'h0000_4000, rand_line(), 0, 0);
    do_write(32'h0000_5000, rand_line(), 1);
    do_read(32'h0000_6000, rand_line(), 0, 1);

    // Reset in the middle of a read burst.
    line = rand_line();
    dfp_addr = 32'h0000_7020;
    dfp_read = 1'b1;
    bmem_ready = 1'b1;
    step();
    step();
    bmem_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata = line[b*BW +: BW];
      step();
    end
    bmem_rdata = line[2*BW +: BW];
    rst = 1'b1;
    dfp_read = 1'b0;
    #1;
    check_zero_outputs("midrst");
    step();
    rst = 1'b0;
    last_rdata = '0;
    resp_seen = 0;
    for (int b = 2; b < int'(BL); b++) begin
      bmem_rdata = line[b*BW +: BW];
      step();
      if (dfp_resp) resp_seen++;
    end
    bmem_rvalid = 1'b0;
    step();
    if (dfp_resp) resp_seen++;
    check("midrst_no_resp", LW'(resp_seen), '0);
    do_read(32'h0000_7020, rand_line(), 0, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      addr = $urandom;
      line = rand_line();
      if ($urandom_range(0, 1) == 0) begin
        do_read(addr, line, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end else begin
        do_write(addr, line, int'($urandom_range(0, 3)));
      end
    end

    // Read whose beats never arrive.
    dfp_addr = 32'h0000_8000;
    dfp_read = 1'b1;
    bmem_ready = 1'b1;
    step();
    step();
    bmem_ready = 1'b0;
`ifdef DFP_BURST_RESPONDER_TIMEOUT_EN
    begin
      int k;
      k = 1;
      while (!dfp_resp && k < 40) begin
        check("tmo_err_early", LW'(bmem_err), '0);
        step();
        k++;
      end
      check("tmo_cycle", LW'(k), LW'(16));
      check("tmo_err", LW'(bmem_err), LW'(1));
      check("tmo_rdata", dfp_rdata, '0);
      dfp_read = 1'b0;
      step();
      check("tmo_resp_pulse", LW'(dfp_resp), '0);
      check("tmo_err_sticky", LW'(bmem_err), LW'(1));
    end
`else
    resp_seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (dfp_resp) resp_seen++;
    end
    check("stall_no_resp", LW'(resp_seen), '0);
    check("stall_no_err", LW'(bmem_err), '0);
    dfp_read = 1'b0;
`endif
    rst = 1'b1;
    step();
    check_zero_outputs("final_reset");
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
